synch_debounce_detect: RTL and testbench
========================================

SYNCH_DEBOUNCE_DETECT -- requirements
Module: synch_debounce_detect

Interface
REQ-001 Parameter WIDTH, default 4, number of independent asynchronous input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flops per channel (2..4).
REQ-003 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles needed to accept a new level (1..65535).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 asynch_sig_in  input  WIDTH  asynchronous raw inputs, one bit per channel.
REQ-007 clr  input  WIDTH  per-channel clear of the sticky pend bit.
REQ-008 level  output  WIDTH  registered, filtered, synchronized level per channel.
REQ-009 rise_edge  output  WIDTH  registered one-cycle pulse when level goes 0->1.
REQ-010 fall_edge  output  WIDTH  registered one-cycle pulse when level goes 1->0.
REQ-011 pend  output  WIDTH  sticky per-channel rise flag, held until cleared.

Function
REQ-012 Each channel SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is "synced".
REQ-013 With debounce enabled, each channel SHALL keep a counter cnt: if synced == level, cnt <= 0; else if cnt == DEBOUNCE_CYCLES-1, level <= synced and cnt <= 0; else cnt <= cnt+1.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES synced cycles SHALL leave level unchanged and SHALL reset cnt to 0 when synced returns.
REQ-015 Latency: an input change held stable SHALL appear on level exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples it.
REQ-016 rise_edge[i]/fall_edge[i] SHALL assert in the same cycle the new level[i] first appears, for exactly one cycle; never both.
REQ-017 pend[i] SHALL set on rise_edge[i] and clear when clr[i]=1; simultaneous set and clr SHALL leave pend[i]=1 (set wins).
REQ-018 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-019 cnt width SHALL be the minimum bits to hold DEBOUNCE_CYCLES-1 (at least 1); cnt SHALL never wrap.

Reset
REQ-020 While rst=1 at a clock edge, all sync flops, cnt, level, rise_edge, fall_edge and pend SHALL be 0.
REQ-021 Reset mid-debounce SHALL discard the count; no edge pulse SHALL be generated by reset itself.
REQ-022 An input held high through reset release SHALL produce one rise_edge after the REQ-015 latency, counted from the first post-reset edge.

Configuration
REQ-023 Macro SYNCH_DEBOUNCE_EN defined: debounce counters per REQ-013..REQ-015.
REQ-024 Macro undefined: no counters; level <= synced every cycle (behaves as DEBOUNCE_CYCLES=1); latency SYNC_STAGES+1; DEBOUNCE_CYCLES ignored.

Structure
REQ-025 Shared package synch_pkg SHALL hold SYNC_STAGES_MIN=2, SYNC_STAGES_MAX=4, and the counter-width function used in REQ-019.
REQ-026 Sub-module synch_chain (WIDTH-wide, SYNC_STAGES-deep flop chain with synchronous reset) SHALL implement REQ-012; edge, debounce and pend logic stay in the top.

Verification
REQ-027 Defaults, macro on: ch0 0->1 held -> level[0]=1 and rise_edge[0] one-cycle pulse at edge 6 after sampling; pend[0]=1 thereafter.
REQ-028 Macro on: ch1 high for 3 synced cycles, then low -> level[1], rise_edge[1], pend[1] remain 0.
REQ-029 pend[2] set; clr[2]=1 in the same cycle as a new rise_edge[2] -> pend[2]=1; clr[2]=1 next cycle -> pend[2]=0.
REQ-030 All 4 channels 0->1 together, then 1->0 together -> 4 simultaneous rise pulses, later 4 simultaneous fall pulses, no cross-talk.
REQ-031 rst=1 asserted with cnt=2 on ch3 -> all outputs 0 next cycle; input still high after release -> single rise_edge[3] 6 edges later.
REQ-032 Macro off, SYNC_STAGES=3: 1-cycle input pulse sampled -> level pulse of 1 cycle at edge 4 with rise_edge then fall_edge.

Source files
------------

// File: rtl/synch_pkg.sv
// synch_pkg: shared limits and debounce-counter sizing for synch_debounce_detect
package synch_pkg;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction
endpackage

// File: rtl/synch_chain.sv
// synch_chain: WIDTH-wide multi-flop synchronizer with synchronous reset
module synch_chain
  import synch_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  // Depth is held inside the supported range so the shift slice stays legal.
  localparam int N = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                     (STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : STAGES;
  logic [N-1:0][WIDTH-1:0] sync_q;
  always_ff @(posedge clk)
    sync_q <= rst ? '0 : {sync_q[N-2:0], d_i};
  assign q_o = sync_q[N-1];
endmodule

// File: rtl/synch_debounce_detect.sv
// synch_debounce_detect: per-channel synchronizer, debounce filter, edge pulses and sticky rise flag.
// Define SYNCH_DEBOUNCE_EN to enable the debounce counters; otherwise level follows synced directly.
module synch_debounce_detect
  import synch_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] asynch_sig_in,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise_edge,
  output logic [WIDTH-1:0] fall_edge,
  output logic [WIDTH-1:0] pend
);
  logic [WIDTH-1:0] synced, level_d, level_q, rise_q, fall_q, pend_q;
  synch_chain #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_chain (
    .clk (clk),
    .rst (rst),
    .d_i (asynch_sig_in),
    .q_o (synced)
  );
`ifdef SYNCH_DEBOUNCE_EN
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    logic [CW-1:0] cnt_q, cnt_d;
    logic          differ, done;
    assign differ     = synced[i] ^ level_q[i];
    assign done       = differ && (cnt_q == CNT_MAX);
    // Any return to the current level restarts the stability count.
    assign cnt_d      = (!differ || done) ? '0 : cnt_q + 1'b1;
    assign level_d[i] = done ? synced[i] : level_q[i];
    always_ff @(posedge clk)
      cnt_q <= rst ? '0 : cnt_d;
  end
`else
  assign level_d = synced;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      pend_q  <= '0;
    end else begin
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
      // A visible rise pulse beats a clear presented in the same cycle.
      pend_q  <= rise_q | (pend_q & ~clr);
    end
  assign level     = level_q;
  assign rise_edge = rise_q;
  assign fall_edge = fall_q;
  assign pend      = pend_q;
endmodule

// File: tb/tb_synch_debounce_detect.sv
// tb_synch_debounce_detect: directed and randomized checks against a sample-history reference model
module tb_synch_debounce_detect;
  localparam int W   = 4;
  localparam int S   = 2;
  localparam int DEB = 4;
`ifdef SYNCH_DEBOUNCE_EN
  localparam int D = DEB;
`else
  localparam int D = 1;
`endif
  localparam int LAT = S + D;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sig, clr_v;
  logic [W-1:0] level, rise_edge, fall_edge, pend;
  logic [W-1:0] lm, rm, fm, pm;
  logic [W-1:0] sq[$];
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  synch_debounce_detect #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk           (clk),
    .rst           (rst),
    .asynch_sig_in (sig),
    .clr           (clr_v),
    .level         (level),
    .rise_edge     (rise_edge),
    .fall_edge     (fall_edge),
    .pend          (pend)
  );

  // Model: sq holds the raw input captured at each edge; the synced value seen
  // at an edge is the capture S edges earlier. A channel's level flips once the
  // last D synced values all disagree with it.
  task automatic model_reset();
    sq.delete();
    for (int i = 0; i < S + D; i++) sq.push_back('0);
    lm = '0; rm = '0; fm = '0; pm = '0;
  endtask

  task automatic step(input logic [W-1:0] a, input logic [W-1:0] c, input logic r);
    logic [W-1:0] flip;
    sig = a; clr_v = c; rst = r;
    @(posedge clk);
    if (r) model_reset();
    else begin
      flip = '1;
      for (int i = 0; i < D; i++) flip &= sq[sq.size() - S - i] ^ lm;
      pm = rm | (pm & ~c);
      lm = lm ^ flip;
      rm = flip & lm;
      fm = flip & ~lm;
      sq.push_back(a);
      void'(sq.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int n = 0; n < 3; n++) begin
      step(W'($urandom), W'($urandom), 1'b1);
      checks++;
      if ({level, rise_edge, fall_edge, pend} !== '0) begin
        errors++;
        $display("FAIL reset n=%0d: got lvl=%h rise=%h fall=%h pend=%h, want all 0", n, level, rise_edge, fall_edge, pend);
      end
    end
  endtask

  task automatic test_single_rise();
    step('0, '0, 1'b1);
    for (int n = 1; n <= LAT + 3; n++) begin
      step(4'b0001, '0, 1'b0);
      checks++;
      if ({level, rise_edge, fall_edge, pend} !== {lm, rm, fm, pm}) begin
        errors++;
        $display("FAIL single_rise model n=%0d: got %h %h %h %h want %h %h %h %h", n, level, rise_edge, fall_edge, pend, lm, rm, fm, pm);
      end
      checks++;
      if ({level[0], rise_edge[0], pend[0]} !== {1'(n >= LAT), 1'(n == LAT), 1'(n > LAT)}) begin
        errors++;
        $display("FAIL single_rise latency n=%0d: got lvl=%b rise=%b pend=%b want %b %b %b", n, level[0], rise_edge[0], pend[0], n >= LAT, n == LAT, n > LAT);
      end
    end
  endtask

  task automatic test_glitch();
    step('0, '0, 1'b1);
    for (int n = 0; n < D - 1; n++) step(4'b0010, '0, 1'b0);
    for (int n = 0; n < 2 * LAT; n++) begin
      step('0, '0, 1'b0);
      checks++;
      if ({level, rise_edge, fall_edge, pend} !== {lm, rm, fm, pm}) begin
        errors++;
        $display("FAIL glitch n=%0d: got %h %h %h %h want %h %h %h %h", n, level, rise_edge, fall_edge, pend, lm, rm, fm, pm);
      end
    end
  endtask

  task automatic test_pend_clr();
    step('0, '0, 1'b1);
    for (int n = 0; n < LAT + 1; n++) step(4'b0100, '0, 1'b0);
    for (int n = 0; n < LAT + 1; n++) step('0, '0, 1'b0);
    for (int n = 0; n < LAT; n++) step(4'b0100, '0, 1'b0);
    checks++;
    if (rise_edge[2] !== 1'b1 || pend[2] !== 1'b1) begin
      errors++;
      $display("FAIL pend_clr rise: got rise=%b pend=%b want 1 1", rise_edge[2], pend[2]);
    end
    step(4'b0100, 4'b0100, 1'b0);
    checks++;
    if (pend[2] !== 1'b1 || pend !== pm) begin
      errors++;
      $display("FAIL pend_clr set_wins: got pend=%h want %h (bit2=1)", pend, pm);
    end
    step(4'b0100, 4'b0100, 1'b0);
    checks++;
    if (pend[2] !== 1'b0 || pend !== pm) begin
      errors++;
      $display("FAIL pend_clr clear: got pend=%h want %h (bit2=0)", pend, pm);
    end
  endtask

  task automatic test_all_channels();
    step('0, '0, 1'b1);
    for (int ph = 0; ph < 2; ph++)
      for (int n = 1; n <= LAT + 2; n++) begin
        step(ph == 0 ? 4'hF : 4'h0, '0, 1'b0);
        checks++;
        if ({level, rise_edge, fall_edge, pend} !== {lm, rm, fm, pm}) begin
          errors++;
          $display("FAIL all_ch model ph=%0d n=%0d: got %h %h %h %h want %h %h %h %h", ph, n, level, rise_edge, fall_edge, pend, lm, rm, fm, pm);
        end
        checks++;
        if ((ph == 0 ? rise_edge : fall_edge) !== (n == LAT ? 4'hF : 4'h0)) begin
          errors++;
          $display("FAIL all_ch pulse ph=%0d n=%0d: got rise=%h fall=%h", ph, n, rise_edge, fall_edge);
        end
      end
  endtask

  task automatic test_reset_mid();
    step('0, '0, 1'b1);
    for (int n = 0; n < S + 2; n++) step(4'b1000, '0, 1'b0);
    step(4'b1000, '0, 1'b1);
    checks++;
    if ({level, rise_edge, fall_edge, pend} !== '0) begin
      errors++;
      $display("FAIL reset_mid zero: got %h %h %h %h want 0", level, rise_edge, fall_edge, pend);
    end
    for (int n = 1; n <= LAT + 2; n++) begin
      step(4'b1000, '0, 1'b0);
      checks++;
      if ({level, rise_edge, fall_edge, pend} !== {lm, rm, fm, pm} || rise_edge !== (n == LAT ? 4'b1000 : 4'b0000)) begin
        errors++;
        $display("FAIL reset_mid n=%0d: got %h %h %h %h want %h %h %h %h", n, level, rise_edge, fall_edge, pend, lm, rm, fm, pm);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a = '0;
    step('0, '0, 1'b1);
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < W; b++) if ($urandom_range(5) == 0) a[b] = ~a[b];
      step(a, W'($urandom) & W'($urandom), $urandom_range(99) == 0);
      checks++;
      if ({level, rise_edge, fall_edge, pend} !== {lm, rm, fm, pm}) begin
        errors++;
        $display("FAIL random n=%0d: got %h %h %h %h want %h %h %h %h", n, level, rise_edge, fall_edge, pend, lm, rm, fm, pm);
      end
    end
  endtask

  initial begin
    sig = '0; clr_v = '0; rst = 1'b1;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_rise();
    test_glitch();
    test_pend_clr();
    test_all_channels();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
